// File: rtl/pio_lcd_status_in.sv
// pio_lcd_status_in
// Avalon-MM input PIO for LCD-side status lines (busy, ready, touch/key
// strobes). Each line passes through a two-flop synchroniser, a per-bit
// debounce filter and an edge detector feeding sticky, software-cleared
// capture bits. A per-bit mask turns captured edges into a level IRQ.
//
// Register map (word address):
//   0 : debounced level (read-only)
//   1 : reads 0
//   2 : irq mask (read/write)
//   3 : edge capture (read, write-1-to-clear)

module pio_lcd_status_in #(
  parameter int unsigned WIDTH           = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_stable_d;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_capture;

  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_event;
  logic             w_wr;
  logic             w_wr_mask;
  logic             w_wr_edge;
  logic [WIDTH-1:0] w_clear;
  logic             w_unused;

  // Upper write-data bits beyond WIDTH carry no meaning for this port.
  assign w_unused = ^writedata;

  // Two-flop synchroniser for the asynchronous status lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
      // With no filtering the debounced level simply tracks the synchroniser.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_stable <= '0;
        end else begin
          r_stable <= r_sync2;
        end
      end
    end else begin : g_debounce
      localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] r_cnt [WIDTH];

      // Per-bit persistence counter: a differing level must hold for
      // DEBOUNCE_CYCLES consecutive cycles before it is accepted; any return
      // to the accepted level restarts the count.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_stable <= '0;
          for (int unsigned i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= '0;
          end
        end else begin
          for (int unsigned i = 0; i < WIDTH; i++) begin
            if (r_sync2[i] == r_stable[i]) begin
              r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
              r_stable[i] <= r_sync2[i];
              r_cnt[i]    <= '0;
            end else begin
              r_cnt[i] <= r_cnt[i] + 1'b1;
            end
          end
        end
      end
    end
  endgenerate

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stable_d <= '0;
    end else begin
      r_stable_d <= r_stable;
    end
  end

  // Edge event selection.
  always_comb begin
    w_rise  = r_stable & ~r_stable_d;
    w_fall  = ~r_stable & r_stable_d;
    w_event = '0;
    case (EDGE_TYPE)
      0:       w_event = w_rise;
      1:       w_event = w_fall;
      default: w_event = w_rise | w_fall;
    endcase
  end

  // Bus write decode.
  always_comb begin
    w_wr      = chipselect & ~write_n;
    w_wr_mask = w_wr && (address == ADDR_MASK);
    w_wr_edge = w_wr && (address == ADDR_EDGE);
    w_clear   = w_wr_edge ? writedata[WIDTH-1:0] : '0;
  end

  // IRQ mask register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_mask <= '0;
    end else if (w_wr_mask) begin
      r_irq_mask <= writedata[WIDTH-1:0];
    end
  end

  // Sticky edge capture; the OR with the new event is applied after the
  // clear so a same-cycle event always survives a write-1-to-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_edge_capture <= '0;
    end else begin
      r_edge_capture <= (r_edge_capture & ~w_clear) | w_event;
    end
  end

  // Combinational read mux, zero-extended, zero when not selected.
  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        ADDR_DATA: readdata = 32'(r_stable);
        ADDR_MASK: readdata = 32'(r_irq_mask);
        ADDR_EDGE: readdata = 32'(r_edge_capture);
        default:   readdata = '0;
      endcase
    end
  end

  // Level interrupt from any enabled captured edge.
  always_comb begin
    irq = |(r_edge_capture & r_irq_mask);
  end

endmodule

// File: tb/tb_pio_lcd_status_in.sv
// Bench for pio_lcd_status_in: two instances (N=16 rising edge, N=0 any edge)
// share all stimulus; a history-window reference model predicts both on
// every cycle, and directed sections pin key latencies with literals.

module tb_pio_lcd_status_in;

  localparam int W  = 6;
  localparam int HD = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [W-1:0]  in_port = '0;
  logic [31:0]   rd_a, rd_b;
  logic          irq_a, irq_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pio_lcd_status_in #(.WIDTH(6), .DEBOUNCE_CYCLES(16), .EDGE_TYPE(0)) u_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_a), .irq(irq_a)
  );

  pio_lcd_status_in #(.WIDTH(6), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) u_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_b), .irq(irq_b)
  );

  // ---------------- reference model ----------------
  // hist[0] is in_port as sampled at the previous edge, hist[k] the one
  // k edges earlier; so hist[1..N] are the last N synchronised values.
  logic [W-1:0] hist [HD];
  logic [W-1:0] m_stable [2];
  logic [W-1:0] m_stable_d [2];
  logic [W-1:0] m_cap [2];
  logic [W-1:0] m_mask [2];
  logic [W-1:0] m_ev, m_ns, m_clr;
  logic         m_held;

  function automatic int n_of(input int j);
    return (j == 0) ? 16 : 0;
  endfunction

  function automatic int et_of(input int j);
    return (j == 0) ? 0 : 2;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < 2; j++) begin
        m_stable[j] = '0; m_stable_d[j] = '0; m_cap[j] = '0; m_mask[j] = '0;
      end
      for (int k = 0; k < HD; k++) hist[k] = '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        case (et_of(j))
          0:       m_ev = m_stable[j] & ~m_stable_d[j];
          1:       m_ev = ~m_stable[j] & m_stable_d[j];
          default: m_ev = m_stable[j] ^ m_stable_d[j];
        endcase
        m_clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
        m_ns = m_stable[j];
        for (int b = 0; b < W; b++) begin
          if (n_of(j) == 0) begin
            m_ns[b] = hist[1][b];
          end else begin
            m_held = 1'b1;
            for (int k = 1; k <= n_of(j); k++)
              if (hist[k][b] == m_stable[j][b]) m_held = 1'b0;
            if (m_held) m_ns[b] = ~m_stable[j][b];
          end
        end
        m_stable_d[j] = m_stable[j];
        m_stable[j]   = m_ns;
        m_cap[j]      = (m_cap[j] & ~m_clr) | m_ev;
        if (chipselect && !write_n && address == 2'd2) m_mask[j] = writedata[W-1:0];
      end
      for (int k = HD - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = in_port;
    end
  end

  function automatic logic [31:0] exp_rd(input int j);
    if (!chipselect) return 32'h0;
    case (address)
      2'd0:    return 32'(m_stable[j]);
      2'd2:    return 32'(m_mask[j]);
      2'd3:    return 32'(m_cap[j]);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic exp_irq(input int j);
    return |(m_cap[j] & m_mask[j]);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=0x%0h exp=0x%0h", name, $time, got, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("cyc_rd_a", rd_a, exp_rd(0));
      check("cyc_irq_a", {31'b0, irq_a}, {31'b0, exp_irq(0)});
      check("cyc_rd_b", rd_b, exp_rd(1));
      check("cyc_irq_b", {31'b0, irq_b}, {31'b0, exp_irq(1)});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic read_check(input string name, input logic [1:0] a,
                            input logic [31:0] exp, input bit use_b);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    #1;
    check(name, use_b ? rd_b : rd_a, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    wait_cyc(3);
    reset = 1'b0;

    // Reset state
    read_check("rst_addr0", 2'd0, 32'h0, 1'b0);
    read_check("rst_addr2", 2'd2, 32'h0, 1'b0);
    read_check("rst_addr3", 2'd3, 32'h0, 1'b0);
    check("rst_irq", {31'b0, irq_a}, 32'h0);

    // Rising bit 0: level after 18 edges, capture one edge later, no irq
    @(negedge clk);
    in_port = 6'h01; chipselect = 1'b1; write_n = 1'b1; address = 2'd0;
    repeat (17) @(posedge clk);
    #1 check("lat_pre", rd_a, 32'h0);
    @(posedge clk);
    #1 check("lat_stable", rd_a, 32'h1);
    check("model_stable", 32'(m_stable[0]), 32'h1);
    @(negedge clk) address = 2'd3;
    @(posedge clk);
    #1 check("lat_cap", rd_a, 32'h1);
    check("lat_irq_masked", {31'b0, irq_a}, 32'h0);

    // Masked irq on a fresh rising edge, then W1C
    bus_write(2'd2, 32'h1);
    @(negedge clk) in_port = 6'h00;
    wait_cyc(25);
    bus_write(2'd3, 32'hFFFF_FFFF);
    @(negedge clk);
    in_port = 6'h01; chipselect = 1'b1; write_n = 1'b1; address = 2'd3;
    repeat (18) @(posedge clk);
    #1 check("irq_pre", {31'b0, irq_a}, 32'h0);
    @(posedge clk);
    #1 check("irq_set", {31'b0, irq_a}, 32'h1);
    @(negedge clk);
    write_n = 1'b0; writedata = 32'h1;
    @(posedge clk);
    #1 check("irq_clr", {31'b0, irq_a}, 32'h0);
    @(negedge clk) write_n = 1'b1;
    #1 check("cap_clr", rd_a, 32'h0);
    bus_write(2'd2, 32'h0);

    // Glitch of 10 cycles on bit 3 is rejected; a 16-cycle hold is accepted
    @(negedge clk) in_port = 6'h00;
    wait_cyc(25);
    bus_write(2'd3, 32'hFFFF_FFFF);
    @(negedge clk) in_port = 6'h08;
    wait_cyc(10);
    in_port = 6'h00;
    wait_cyc(30);
    read_check("glitch_lvl", 2'd0, 32'h0, 1'b0);
    read_check("glitch_cap", 2'd3, 32'h0, 1'b0);
    @(negedge clk);
    in_port = 6'h08; chipselect = 1'b1; write_n = 1'b1; address = 2'd0;
    repeat (17) @(posedge clk);
    #1 check("hold_pre", rd_a, 32'h0);
    @(posedge clk);
    #1 check("hold_lvl", rd_a, 32'h8);

    // W1C of bit 2 in the same cycle a bit-2 event is captured: set wins
    wait_cyc(5);
    bus_write(2'd3, 32'hFFFF_FFFF);
    @(negedge clk) in_port = 6'h0C;
    repeat (18) @(posedge clk);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h4;
    @(negedge clk) write_n = 1'b1;
    #1 check("set_wins", rd_a, 32'h4);

    // Any-edge, no debounce instance: falling bit 5 captured on 4th edge
    @(negedge clk) in_port = 6'h2C;
    wait_cyc(25);
    bus_write(2'd3, 32'hFFFF_FFFF);
    @(negedge clk);
    in_port = 6'h0C; chipselect = 1'b1; write_n = 1'b1; address = 2'd3;
    repeat (3) @(posedge clk);
    #1 check("any_pre", rd_b, 32'h0);
    @(posedge clk);
    #1 check("any_cap", rd_b, 32'h20);
    check("fall_ignored_a", rd_a, 32'h0);
    bus_write(2'd3, 32'hFFFF_FFFF);
    read_check("any_w1c", 2'd3, 32'h0, 1'b1);

    // Async reset mid-debounce with irq high
    bus_write(2'd2, 32'h3F);
    @(negedge clk) in_port = 6'h0E;
    wait_cyc(22);
    check("irq_before_rst", {31'b0, irq_a}, 32'h1);
    @(negedge clk) in_port = 6'h1E;
    wait_cyc(5);
    #2 reset = 1'b1;
    chipselect = 1'b1; write_n = 1'b1; address = 2'd3;
    #1 check("rst_async_irq_a", {31'b0, irq_a}, 32'h0);
    check("rst_async_irq_b", {31'b0, irq_b}, 32'h0);
    check("rst_async_cap", rd_a, 32'h0);
    address = 2'd2;
    #1 check("rst_async_mask", rd_a, 32'h0);
    in_port = 6'h3F;
    wait_cyc(2);
    reset = 1'b0; address = 2'd3;
    repeat (18) @(posedge clk);
    #1 check("pwr_pre", rd_a, 32'h0);
    @(posedge clk);
    #1 check("pwr_cap", rd_a, 32'h3F);

    // Randomised traffic, checked by the per-cycle comparison
    bus_write(2'd3, 32'hFFFF_FFFF);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        int unsigned b;
        b = $urandom_range(0, W - 1);
        in_port[b] = ~in_port[b];
      end
      chipselect = 1'($urandom_range(0, 1));
      address    = 2'($urandom_range(0, 3));
      write_n    = ($urandom_range(0, 7) != 0);
      writedata  = $urandom;
      if (c == 2000) begin
        #2 reset = 1'b1;
        #1 check("rnd_rst_irq", {31'b0, irq_a | irq_b}, 32'h0);
        @(negedge clk) reset = 1'b0;
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
